loop_trace_capture: RTL and testbench

- Downstream monitor for the nested-loop sequencer (outputs c1, act1, act2, phase i).
- Detects each outer-loop event (the cycle where act1 takes the value of act2) and captures {event index, captured value} into an internal FIFO. A consumer drains the FIFO over a valid/ready handshake.
- Checks every captured value against the expected k*STEP.
- Checks the per-round event count at each round end.
- Raises sticky error and overflow flags.

---
 rtl/loop_trace_capture.sv | 93 +++++++++
 tb/tb_loop_trace_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/loop_trace_capture.sv
// Monitor for the nested-loop sequencer: captures outer-loop events into a
// first-word fall-through FIFO and checks event values and per-round counts.
module loop_trace_capture #(
  parameter int STEP    = 10,
  parameter int OUTER_N = 10,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    c1,
  input  logic [7:0]    act2,
  input  logic [1:0]    i,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [11:0]   ev_data,
  output logic          round_done,
  output logic [7:0]    round_cnt,
  output logic          err,
  output logic          ovf,
  output logic [AW:0]   level
);

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] val;
  } ev_entry_t;

  logic [7:0]    k;
  logic [7:0]    nxt;
  logic [1:0]    i_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  ev_entry_t     mem [DEPTH];

  logic      ev;
  logic      round_end;
  logic      full;
  logic      pop;
  logic      push;
  ev_entry_t wr_entry;

  // nxt always equals k*STEP, so it doubles as the expected captured value
  assign ev        = (i == 2'd0) && (c1 == nxt) && (k < 8'(OUTER_N));
  assign round_end = (i_q == 2'd0) && (i == 2'd1);
  assign full      = (level == (AW+1)'(DEPTH));
  assign ev_valid  = (level != '0);
  assign pop       = ev_valid && ev_ready;
  assign push      = ev && (!full || pop);
  assign wr_entry  = '{idx: k[3:0], val: act2};
  assign ev_data   = ev_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      nxt        <= '0;
      i_q        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      round_done <= 1'b0;
      round_cnt  <= '0;
      err        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      i_q        <= i;
      round_done <= round_end;
      if (ev) begin
        k   <= k + 8'd1;
        nxt <= nxt + 8'(STEP);
        if (act2 != nxt) err <= 1'b1;
        if (full && !pop) ovf <= 1'b1;
      end else if (round_end) begin
        k         <= '0;
        nxt       <= '0;
        round_cnt <= round_cnt + 8'd1;
        if (k != 8'(OUTER_N)) err <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_trace_capture.sv
// Directed bench for loop_trace_capture with a 4-entry FIFO.
module tb_loop_trace_capture;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  c1, act2;
  logic [1:0]  i;
  logic        ev_valid, ev_ready;
  logic [11:0] ev_data;
  logic        round_done;
  logic [7:0]  round_cnt;
  logic        err, ovf;
  logic [AW:0] level;

  int tests = 0;
  int fails = 0;
  logic [11:0] popq [$];

  loop_trace_capture #(.STEP(10), .OUTER_N(10), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .c1(c1), .act2(act2), .i(i),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .round_done(round_done), .round_cnt(round_cnt),
    .err(err), .ovf(ovf), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // one clock with the given inputs; records the entry popped at this edge
  task automatic cyc(input logic [7:0] c, input logic [7:0] a, input logic [1:0] ph);
    c1 = c; act2 = a; i = ph;
    if (ev_valid && ev_ready) popq.push_back(ev_data);
    @(posedge clk); #1;
  endtask

  task automatic drive(input int lo, input int hi, input int bad_c, input logic [7:0] bad_v);
    for (int c = lo; c <= hi; c++) cyc(8'(c), (c == bad_c) ? bad_v : 8'(c), 2'd0);
  endtask

  task automatic rst_dut();
    rst = 1'b1; ev_ready = 1'b0;
    cyc(8'd0, 8'd0, 2'd0);
    rst = 1'b0;
    popq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ev_ready = 1'b0;
    cyc(8'd0, 8'd0, 2'd0);
    rst = 1'b0;
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    tests++; if (ev_data !== 12'h000) begin fails++; $display("FAIL reset_ev_data: got %h want 000", ev_data); end
    tests++; if (round_done !== 1'b0) begin fails++; $display("FAIL reset_round_done: got %b want 0", round_done); end
    tests++; if (round_cnt !== 8'd0) begin fails++; $display("FAIL reset_round_cnt: got %0d want 0", round_cnt); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
  endtask

  task automatic test_nominal();
    logic [11:0] exp;
    rst_dut();
    ev_ready = 1'b1;
    drive(0, 99, -1, 8'd0);
    tests++; if (popq.size() != 10) begin fails++; $display("FAIL nom_count: got %0d want 10", popq.size()); end
    for (int n = 0; n < popq.size(); n++) begin
      exp = {4'(n), 8'(n * 10)};
      tests++; if (popq[n] !== exp) begin fails++; $display("FAIL nom_entry%0d: got %h want %h", n, popq[n], exp); end
    end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL nom_level: got %0d want 0", level); end
    cyc(8'd0, 8'd0, 2'd1);
    tests++; if (round_done !== 1'b1) begin fails++; $display("FAIL nom_round_done: got %b want 1", round_done); end
    tests++; if (round_cnt !== 8'd1) begin fails++; $display("FAIL nom_round_cnt: got %0d want 1", round_cnt); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL nom_err: got %b want 0", err); end
    cyc(8'd0, 8'd0, 2'd1);
    tests++; if (round_done !== 1'b0) begin fails++; $display("FAIL nom_round_done_pulse: got %b want 0", round_done); end
    tests++; if (round_cnt !== 8'd1) begin fails++; $display("FAIL nom_round_cnt_hold: got %0d want 1", round_cnt); end
  endtask

  task automatic test_mismatch();
    rst_dut();
    ev_ready = 1'b1;
    drive(0, 39, -1, 8'd0);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mis_err_before: got %b want 0", err); end
    drive(40, 40, 40, 8'd41);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err_after: got %b want 1", err); end
    drive(41, 99, -1, 8'd0);
    tests++; if (popq.size() != 10) begin fails++; $display("FAIL mis_count: got %0d want 10", popq.size()); end
    if (popq.size() > 4) begin
      tests++; if (popq[4] !== 12'h429) begin fails++; $display("FAIL mis_entry4: got %h want 429", popq[4]); end
    end
    cyc(8'd0, 8'd0, 2'd1);
    drive(0, 99, -1, 8'd0);
    cyc(8'd0, 8'd0, 2'd1);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err_sticky: got %b want 1", err); end
    tests++; if (round_cnt !== 8'd2) begin fails++; $display("FAIL mis_round_cnt: got %0d want 2", round_cnt); end
  endtask

  task automatic test_short_round();
    rst_dut();
    ev_ready = 1'b1;
    drive(0, 55, -1, 8'd0);
    tests++; if (popq.size() != 6) begin fails++; $display("FAIL short_count: got %0d want 6", popq.size()); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL short_err_before: got %b want 0", err); end
    cyc(8'd0, 8'd0, 2'd1);
    tests++; if (round_done !== 1'b1) begin fails++; $display("FAIL short_round_done: got %b want 1", round_done); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", err); end
    ev_ready = 1'b0;
    drive(0, 0, -1, 8'd0);
    tests++; if (ev_valid !== 1'b1) begin fails++; $display("FAIL short_restart_valid: got %b want 1", ev_valid); end
    tests++; if (ev_data !== 12'h000) begin fails++; $display("FAIL short_restart_data: got %h want 000", ev_data); end
  endtask

  task automatic test_overflow();
    logic [11:0] exp;
    rst_dut();
    drive(0, 99, -1, 8'd0);
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL ovf_level: got %0d want 4", level); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    tests++; if (ev_data !== 12'h000) begin fails++; $display("FAIL ovf_head: got %h want 000", ev_data); end
    cyc(8'd0, 8'd0, 2'd1);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ovf_err_count_ok: got %b want 0", err); end
    ev_ready = 1'b1;
    popq.delete();
    repeat (6) cyc(8'd0, 8'd0, 2'd2);
    tests++; if (popq.size() != 4) begin fails++; $display("FAIL ovf_drain_count: got %0d want 4", popq.size()); end
    for (int n = 0; n < popq.size(); n++) begin
      exp = {4'(n), 8'(n * 10)};
      tests++; if (popq[n] !== exp) begin fails++; $display("FAIL ovf_entry%0d: got %h want %h", n, popq[n], exp); end
    end
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", ev_valid); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_push_pop_full();
    rst_dut();
    drive(0, 39, -1, 8'd0);
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL ppf_level_full: got %0d want 4", level); end
    ev_ready = 1'b1;
    drive(40, 40, -1, 8'd0);
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL ppf_level_hold: got %0d want 4", level); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ppf_ovf: got %b want 0", ovf); end
    drive(41, 44, -1, 8'd0);
    tests++; if (popq.size() != 5) begin fails++; $display("FAIL ppf_count: got %0d want 5", popq.size()); end
    if (popq.size() == 5) begin
      tests++; if (popq[0] !== 12'h000) begin fails++; $display("FAIL ppf_first: got %h want 000", popq[0]); end
      tests++; if (popq[4] !== 12'h428) begin fails++; $display("FAIL ppf_last: got %h want 428", popq[4]); end
    end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL ppf_level_end: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    rst_dut();
    drive(0, 99, 50, 8'd7);
    cyc(8'd0, 8'd0, 2'd1);
    tests++; if ({err, ovf, round_cnt} !== {1'b1, 1'b1, 8'd1}) begin fails++; $display("FAIL rmid_pre: got err=%b ovf=%b rc=%0d want 1 1 1", err, ovf, round_cnt); end
    drive(0, 34, -1, 8'd0);
    rst = 1'b1;
    cyc(8'd35, 8'd35, 2'd0);
    rst = 1'b0;
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL rmid_level: got %0d want 0", level); end
    tests++; if (ev_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", ev_valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rmid_err: got %b want 0", err); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rmid_ovf: got %b want 0", ovf); end
    tests++; if (round_cnt !== 8'd0) begin fails++; $display("FAIL rmid_round_cnt: got %0d want 0", round_cnt); end
    drive(0, 0, -1, 8'd0);
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL rmid_restart_level: got %0d want 1", level); end
    tests++; if (ev_data !== 12'h000) begin fails++; $display("FAIL rmid_restart_data: got %h want 000", ev_data); end
  endtask

  initial begin
    rst = 1'b1; ev_ready = 1'b0; c1 = '0; act2 = '0; i = '0;
    test_reset();
    test_nominal();
    test_mismatch();
    test_short_round();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
